// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline:
// forwarding, load-use, branch flush, multi-cycle execute and memory-wait stalls.
module pipeline_hazard_ctrl #(
    parameter int REGW   = 4,
    parameter int MC_LAT = 4,
    parameter int CNTW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] rs1D,
    input  logic [REGW-1:0] rs2D,
    input  logic [REGW-1:0] rs1E,
    input  logic [REGW-1:0] rs2E,
    input  logic [REGW-1:0] rdE,
    input  logic [REGW-1:0] rdM,
    input  logic [REGW-1:0] rdW,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memtoregE,
    input  logic            pcsrcE,
    input  logic            mcstartE,
    input  logic            memreqM,
    input  logic            memackM,
    output logic [1:0]      fwdAE,
    output logic [1:0]      fwdBE,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            flushW,
    output logic            busy,
    output logic            mc_done
);

    typedef enum logic [1:0] {RUN, MC, MEM} state_t;

    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic            skip, skip_n;

    logic memstall;
    logic mc_start;
    logic mc_stall;
    logic lwstall;
    logic lw_act;
    logic br_act;

    always_comb begin
        fwdAE = 2'b00;
        if (regwriteM && rdM != '0 && rdM == rs1E)
            fwdAE = 2'b10;
        else if (regwriteW && rdW != '0 && rdW == rs1E)
            fwdAE = 2'b01;
    end

    always_comb begin
        fwdBE = 2'b00;
        if (regwriteM && rdM != '0 && rdM == rs2E)
            fwdBE = 2'b10;
        else if (regwriteW && rdW != '0 && rdW == rs2E)
            fwdBE = 2'b01;
    end

    // skip masks mcstartE of an op that has just finished its stall window
    assign memstall = memreqM & ~memackM;
    assign mc_start = (state != MC) && mcstartE && !memstall && !skip;
    assign mc_stall = !memstall && ((state == MC) || mc_start);
    assign mc_done  = (state == MC) && (cnt == CNTW'(1)) && !memstall;

    assign lwstall = memtoregE && (rdE != '0) &&
                     ((rdE == rs1D) || (rdE == rs2D));
    assign br_act  = pcsrcE && !memstall && !mc_stall;
    assign lw_act  = lwstall && !memstall && !mc_stall && !pcsrcE;

    assign stallF = memstall | mc_stall | lw_act;
    assign stallD = memstall | mc_stall | lw_act;
    assign stallE = memstall | mc_stall;
    assign stallM = memstall;
    assign flushD = br_act;
    assign flushE = br_act | lw_act;
    assign flushM = mc_stall;
    assign flushW = memstall;
    assign busy   = (state != RUN);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        skip_n  = memstall ? skip : 1'b0;
        unique case (state)
            RUN, MEM: begin
                if (memstall) begin
                    state_n = MEM;
                end else if (mc_start) begin
                    state_n = MC;
                    cnt_n   = CNTW'(MC_LAT - 1);
                end else begin
                    state_n = RUN;
                end
            end
            MC: begin
                if (!memstall) begin
                    if (cnt == CNTW'(1)) begin
                        state_n = RUN;
                        cnt_n   = '0;
                        skip_n  = 1'b1;
                    end else begin
                        cnt_n = cnt - CNTW'(1);
                    end
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            skip  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            skip  <= skip_n;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table
// plus multi-cycle, memory-wait, priority and reset sequences.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regwriteM, regwriteW, memtoregE, pcsrcE;
    logic       mcstartE, memreqM, memackM;
    logic [1:0] fwdAE, fwdBE;
    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushM, flushW;
    logic       busy, mc_done;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REGW(4), .MC_LAT(4), .CNTW(3)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .pcsrcE(pcsrcE), .mcstartE(mcstartE),
        .memreqM(memreqM), .memackM(memackM),
        .fwdAE(fwdAE), .fwdBE(fwdBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .busy(busy), .mc_done(mc_done)
    );

    typedef struct {
        logic [3:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       rwM, rwW, mtr, pcs;
        logic [1:0] fa, fb;
        logic [3:0] st, fl;
    } vec_t;

    vec_t vt[12];

    function automatic vec_t mk(
        input logic [3:0] a1D, a2D, a1E, a2E, dE, dM, dW,
        input logic wm, ww, mt, pc,
        input logic [1:0] fa, fb,
        input logic [3:0] st, fl);
        vec_t v;
        v.rs1D = a1D; v.rs2D = a2D; v.rs1E = a1E; v.rs2E = a2E;
        v.rdE = dE; v.rdM = dM; v.rdW = dW;
        v.rwM = wm; v.rwW = ww; v.mtr = mt; v.pcs = pc;
        v.fa = fa; v.fb = fb; v.st = st; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // stall={F,D,E,M}, flush={D,E,M,W}, bd={busy,mc_done}
    task automatic cmp(input string nm, input logic [3:0] st,
                       input logic [3:0] fl, input logic [1:0] bd);
        chk({nm, " stall"}, {4'h0, stallF, stallD, stallE, stallM}, {4'h0, st});
        chk({nm, " flush"}, {4'h0, flushD, flushE, flushM, flushW}, {4'h0, fl});
        chk({nm, " busy/done"}, {6'h0, busy, mc_done}, {6'h0, bd});
    endtask

    task automatic quiet();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
        rdE = 0; rdM = 0; rdW = 0;
        regwriteM = 0; regwriteW = 0; memtoregE = 0; pcsrcE = 0;
        mcstartE = 0; memreqM = 0; memackM = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        vt[0]  = mk(0,0,5,6,0,5,6, 1,1,0,0, 2'b10,2'b01, 4'b0000,4'b0000);
        vt[1]  = mk(0,0,5,5,0,5,5, 1,1,0,0, 2'b10,2'b10, 4'b0000,4'b0000);
        vt[2]  = mk(0,0,0,0,0,0,0, 1,1,0,0, 2'b00,2'b00, 4'b0000,4'b0000);
        vt[3]  = mk(0,0,5,7,0,5,5, 0,1,0,0, 2'b01,2'b00, 4'b0000,4'b0000);
        vt[4]  = mk(0,0,5,6,0,5,6, 0,0,0,0, 2'b00,2'b00, 4'b0000,4'b0000);
        vt[5]  = mk(0,3,0,0,3,0,0, 0,0,1,0, 2'b00,2'b00, 4'b1100,4'b0100);
        vt[6]  = mk(0,0,0,0,0,0,0, 0,0,1,0, 2'b00,2'b00, 4'b0000,4'b0000);
        vt[7]  = mk(4,9,0,0,4,0,0, 0,0,1,0, 2'b00,2'b00, 4'b1100,4'b0100);
        vt[8]  = mk(1,2,0,0,3,0,0, 0,0,1,0, 2'b00,2'b00, 4'b0000,4'b0000);
        vt[9]  = mk(0,0,0,0,0,0,0, 0,0,0,1, 2'b00,2'b00, 4'b0000,4'b1100);
        vt[10] = mk(3,0,0,0,3,0,0, 0,0,1,1, 2'b00,2'b00, 4'b0000,4'b1100);
        vt[11] = mk(3,0,0,0,3,0,0, 0,0,0,0, 2'b00,2'b00, 4'b0000,4'b0000);

        // reset state
        smp();
        chk("reset fwd", {4'h0, fwdAE, fwdBE}, 8'h00);
        cmp("reset", 4'b0000, 4'b0000, 2'b00);
        smp();
        reset = 1'b0;

        // combinational vector table, state stays RUN
        for (int i = 0; i < 12; i++) begin
            step();
            rs1D = vt[i].rs1D; rs2D = vt[i].rs2D;
            rs1E = vt[i].rs1E; rs2E = vt[i].rs2E;
            rdE = vt[i].rdE; rdM = vt[i].rdM; rdW = vt[i].rdW;
            regwriteM = vt[i].rwM; regwriteW = vt[i].rwW;
            memtoregE = vt[i].mtr; pcsrcE = vt[i].pcs;
            smp();
            chk($sformatf("vec%0d fwd", i), {4'h0, fwdAE, fwdBE},
                {4'h0, vt[i].fa, vt[i].fb});
            cmp($sformatf("vec%0d", i), vt[i].st, vt[i].fl, 2'b00);
        end
        step(); quiet();

        // multi-cycle op, branch deferred while stalled
        step(); mcstartE = 1;
        smp(); cmp("mc c1", 4'b1110, 4'b0010, 2'b00);
        step(); pcsrcE = 1;
        smp(); cmp("mc c2", 4'b1110, 4'b0010, 2'b10);
        step(); pcsrcE = 0;
        smp(); cmp("mc c3", 4'b1110, 4'b0010, 2'b10);
        step();
        smp(); cmp("mc c4", 4'b1110, 4'b0010, 2'b11);
        step();
        smp(); cmp("mc after", 4'b0000, 4'b0000, 2'b00);
        step(); mcstartE = 0;
        smp(); cmp("mc idle", 4'b0000, 4'b0000, 2'b00);

        // memory wait: ack after 3 stalled cycles
        step(); memreqM = 1;
        smp(); cmp("mem c1", 4'b1111, 4'b0001, 2'b00);
        step();
        smp(); cmp("mem c2", 4'b1111, 4'b0001, 2'b10);
        step();
        smp(); cmp("mem c3", 4'b1111, 4'b0001, 2'b10);
        step(); memackM = 1;
        smp(); cmp("mem ack", 4'b0000, 4'b0000, 2'b10);
        step(); memreqM = 0; memackM = 0;
        smp(); cmp("mem idle", 4'b0000, 4'b0000, 2'b00);

        // memory stall inside MC freezes the counter at 2
        step(); mcstartE = 1;
        smp(); cmp("pri c1", 4'b1110, 4'b0010, 2'b00);
        step();
        smp(); cmp("pri c2", 4'b1110, 4'b0010, 2'b10);
        step(); memreqM = 1;
        smp(); cmp("pri mem1", 4'b1111, 4'b0001, 2'b10);
        step();
        smp(); cmp("pri mem2", 4'b1111, 4'b0001, 2'b10);
        step(); memackM = 1;
        smp(); cmp("pri ack", 4'b1110, 4'b0010, 2'b10);
        step(); memreqM = 0; memackM = 0;
        smp(); cmp("pri last", 4'b1110, 4'b0010, 2'b11);
        step();
        smp(); cmp("pri after", 4'b0000, 4'b0000, 2'b00);
        step(); mcstartE = 0;

        // reset mid-MC with cnt=2
        step(); mcstartE = 1;
        step();
        step();
        smp(); cmp("rst pre", 4'b1110, 4'b0010, 2'b10);
        #1;
        mcstartE = 0;
        reset = 1'b1;
        #1;
        cmp("rst mid", 4'b0000, 4'b0000, 2'b00);
        #1;
        reset = 1'b0;
        step();
        smp(); cmp("rst idle", 4'b0000, 4'b0000, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
